ex_mem_reg: RTL

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/nzcv_reg.sv | 29 ++
 rtl/ex_mem_reg.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: pipeline payload layout, control and flag bit positions.
package cpu_pkg;

  localparam int XLEN      = 64;
  localparam int REG_IDX_W = 5;
  localparam int CTRL_W    = 3;
  localparam int NZCV_W    = 4;

  // Control bundle bit positions: {reg_write, mem_read, mem_write}
  localparam int CTRL_REG_WRITE = 2;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_MEM_WRITE = 0;

  // Flag bit positions: {N, Z, C, V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // One execute->memory beat as carried by the pipeline register
  typedef struct packed {
    logic [XLEN-1:0]      result;
    logic [XLEN-1:0]      store_data;
    logic [REG_IDX_W-1:0] rd;
    logic [CTRL_W-1:0]    ctrl;
  } ex_mem_payload_t;

  // Control bundle with every enable cleared, used whenever no beat is valid
  function automatic logic [CTRL_W-1:0] ctrl_idle();
    return '0;
  endfunction

endpackage

// File: rtl/nzcv_reg.sv
// Architectural NZCV flag register: 4-bit enabled register, async active-high reset.
module nzcv_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NZCV_W-1:0] d,
  output logic [NZCV_W-1:0] q
);

  logic [NZCV_W-1:0] flag_reg;

  generate
    for (genvar gi = 0; gi < NZCV_W; gi++) begin : g_flag
      // Each flag bit loads together on enable, clears on reset
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          flag_reg[gi] <= 1'b0;
        end else if (en) begin
          flag_reg[gi] <= d[gi];
        end
      end
    end
  endgenerate

  assign q = flag_reg;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register built as a 2-entry skid buffer. in_ready depends only
// on local state, so backpressure from the memory stage never forms a
// combinational path back into execute. Also owns the NZCV flag register.
module ex_mem_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int REG_W  = REG_IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  // execute side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_flags,
  input  logic              in_set_flags,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [2:0]        in_ctrl,
  input  logic              flush,
  // memory side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_rd,
  output logic [2:0]        out_ctrl,
  // architectural flags
  output logic [3:0]        nzcv
);

  ex_mem_payload_t main_reg, skid_reg, in_payload;
  logic            main_valid_reg, skid_valid_reg;
  logic            accept, drain, main_free;

  assign in_payload.result     = in_result;
  assign in_payload.store_data = in_store_data;
  assign in_payload.rd         = in_rd;
  assign in_payload.ctrl       = in_ctrl;

  // Flush swallows the incoming beat, so it never counts as accepted
  assign in_ready  = !skid_valid_reg;
  assign accept    = in_valid && in_ready && !flush;
  assign drain     = main_valid_reg && out_ready;
  assign main_free = !main_valid_reg || drain;

  // Valid bits: flush wins; otherwise skid refills main first, then new beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (flush) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (main_free) begin
      if (skid_valid_reg) begin
        main_valid_reg <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else begin
        main_valid_reg <= accept;
      end
    end else if (accept) begin
      skid_valid_reg <= 1'b1;
    end
  end

  // Main payload: loads only when a beat moves in, so it holds while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_reg <= '0;
    end else if (!flush && main_free) begin
      if (skid_valid_reg) begin
        main_reg <= skid_reg;
      end else if (accept) begin
        main_reg <= in_payload;
      end
    end
  end

  // Skid payload: captures the one beat that arrives while main is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_reg <= '0;
    end else if (accept && !main_free) begin
      skid_reg <= in_payload;
    end
  end

  assign out_valid      = main_valid_reg;
  assign out_result     = main_reg.result;
  assign out_store_data = main_reg.store_data;
  assign out_rd         = main_reg.rd;
  // Stale control left in main after a drain or flush must not reach memory
  assign out_ctrl       = main_valid_reg ? main_reg.ctrl : ctrl_idle();

  nzcv_reg u_nzcv (
    .clk   (clk),
    .reset (reset),
    .en    (accept && in_set_flags),
    .d     (in_flags),
    .q     (nzcv)
  );

endmodule
